keypad_scan_capture: RTL

//  Scans a 4x4 active-low matrix keypad and debounces press and release with one FSM.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/row_scanner.sv | 58 +++++
 rtl/keypad_scan_capture.sv | 139 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key map and column-index helper for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int unsigned NUM_LINES = 4;

   typedef enum logic [1:0] {
      SCAN,
      PRESS_DEB,
      HELD,
      REL_DEB
   } kp_state_t;

   // Rows 0..3 top to bottom, columns 0..3 left to right.
   localparam logic [3:0] KEYMAP [NUM_LINES][NUM_LINES] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // Lowest-index low bit wins when several lines are low at once.
   function automatic logic [1:0] onehot_low_to_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/row_scanner.sv
// Row dwell counter and active-low one-hot row rotation for the keypad matrix.
module row_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic       int_osc,
   input  logic       reset,
   input  logic       advance_en,
   input  logic       freeze,
   output logic [3:0] row,
   output logic [1:0] row_idx,
   output logic       sample_tick
);

   localparam int unsigned DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DIV - 1);

   logic [DW_W-1:0] dwell_q, dwell_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      row_q, row_d;

   assign sample_tick = (dwell_q == DW_LAST);

   // Forced advance beats freeze; a frozen row parks the dwell counter at 0.
   always_comb begin
      dwell_d = dwell_q;
      idx_d   = idx_q;
      if (advance_en) begin
         idx_d   = idx_q + 2'd1;
         dwell_d = '0;
      end else if (freeze) begin
         dwell_d = '0;
      end else if (sample_tick) begin
         idx_d   = idx_q + 2'd1;
         dwell_d = '0;
      end else begin
         dwell_d = dwell_q + DW_W'(1);
      end
      row_d = ~(4'b0001 << idx_d);
   end

   always_ff @(posedge int_osc) begin
      if (reset) begin
         dwell_q <= '0;
         idx_q   <= 2'd0;
         row_q   <= 4'b1110;
      end else begin
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
      end
   end

   assign row     = row_q;
   assign row_idx = idx_q;

endmodule

// File: rtl/keypad_scan_capture.sv
// 4x4 keypad scanner: press/release debounce FSM, one event per press, two-digit history.
module keypad_scan_capture
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic       int_osc,
   input  logic       reset,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   kp_state_t       state_q, state_d;
   logic [DB_W-1:0] dbcnt_q, dbcnt_d;
   logic [1:0]      col_idx_q, col_idx_d;
   logic [1:0]      row_idx;
   logic            sample_tick;
   logic            freeze_c, advance_c, accept_c;
   logic            key_low_c, col_hit_c;

   logic            key_valid_q, key_held_q;
   logic [3:0]      key_code_q, digit_new_q, digit_old_q;

   assign key_low_c = !col[col_idx_q];
   assign col_hit_c = sample_tick && (col != 4'hF);

   row_scanner #(
      .SCAN_DIV (SCAN_DIV)
   ) u_row_scanner (
      .int_osc     (int_osc),
      .reset       (reset),
      .advance_en  (advance_c),
      .freeze      (freeze_c),
      .row         (row),
      .row_idx     (row_idx),
      .sample_tick (sample_tick)
   );

   always_ff @(posedge int_osc) begin
      if (reset) state_q <= SCAN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN:      if (col_hit_c) state_d = PRESS_DEB;
         PRESS_DEB: begin
            if (!key_low_c)             state_d = SCAN;
            else if (dbcnt_q == DB_LAST) state_d = HELD;
         end
         HELD:      if (!key_low_c) state_d = REL_DEB;
         REL_DEB: begin
            if (key_low_c)               state_d = HELD;
            else if (dbcnt_q == DB_LAST) state_d = SCAN;
         end
         default:   state_d = SCAN;
      endcase
   end

   // Row control, debounce count and capture strobes; row stays frozen outside SCAN.
   always_comb begin
      freeze_c  = (state_q != SCAN);
      advance_c = 1'b0;
      accept_c  = 1'b0;
      dbcnt_d   = dbcnt_q;
      col_idx_d = col_idx_q;
      case (state_q)
         SCAN: begin
            dbcnt_d = '0;
            if (col_hit_c) begin
               freeze_c  = 1'b1;
               col_idx_d = onehot_low_to_idx(col);
            end
         end
         PRESS_DEB: begin
            if (!key_low_c) begin
               advance_c = 1'b1;
               dbcnt_d   = '0;
            end else if (dbcnt_q == DB_LAST) begin
               accept_c = 1'b1;
               dbcnt_d  = '0;
            end else begin
               dbcnt_d = dbcnt_q + DB_W'(1);
            end
         end
         HELD: dbcnt_d = '0;
         REL_DEB: begin
            if (key_low_c) begin
               dbcnt_d = '0;
            end else if (dbcnt_q == DB_LAST) begin
               advance_c = 1'b1;
               dbcnt_d   = '0;
            end else begin
               dbcnt_d = dbcnt_q + DB_W'(1);
            end
         end
         default: dbcnt_d = '0;
      endcase
   end

   always_ff @(posedge int_osc) begin
      if (reset) begin
         dbcnt_q     <= '0;
         col_idx_q   <= 2'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         key_code_q  <= 4'h0;
         digit_new_q <= 4'h0;
         digit_old_q <= 4'h0;
      end else begin
         dbcnt_q     <= dbcnt_d;
         col_idx_q   <= col_idx_d;
         key_valid_q <= accept_c;
         key_held_q  <= (state_d == HELD) || (state_d == REL_DEB);
         if (accept_c) begin
            key_code_q  <= KEYMAP[row_idx][col_idx_q];
            digit_new_q <= KEYMAP[row_idx][col_idx_q];
            digit_old_q <= digit_new_q;
         end
      end
   end

   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign key_code  = key_code_q;
   assign digit_new = digit_new_q;
   assign digit_old = digit_old_q;

endmodule
